// File: rtl/midi_uart_tx_pkg.sv
// Shared MIDI transmit constants and FSM state encoding.
// The future receiver reuses these definitions.
package midi_uart_tx_pkg;

    localparam int MIDI_CLK_HZ       = 8000000;
    localparam int MIDI_BAUD         = 31250;
    localparam int MIDI_CLKS_PER_BIT = MIDI_CLK_HZ / MIDI_BAUD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/midi_uart_tx_if.sv
// Byte-stream valid/ready handshake into the MIDI transmitter.
interface midi_uart_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/midi_tx_fifo.sv
// Show-ahead synchronous FIFO holding bytes awaiting serialization.
// The caller never writes when full nor reads when empty.
module midi_tx_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         din,
    input  logic               rd_en,
    output logic [7:0]         dout,
    output logic [FIFO_AW:0]   level
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + {{FIFO_AW{1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{FIFO_AW{1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI 8N1 serializer: FIFO-buffered bytes shifted out LSB first on midi_out.
// midi_out lags the FSM state by one register so every cell is exactly CLKS_PER_BIT long.
module midi_uart_tx
    import midi_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT,
    parameter int FIFO_AW      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    midi_uart_tx_if.slave        tx_if,
    output logic                 midi_out,
    output logic                 busy,
    output logic [FIFO_AW:0]     fifo_level
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH  = 1 << FIFO_AW;

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              midi_out_q, midi_out_d;

    logic              wr_en;
    logic              rd_en;
    logic [7:0]        fifo_dout;
    logic [FIFO_AW:0]  level;
    logic              baud_done;
    logic              fifo_nempty;

    // Ready depends only on the registered level: a same-cycle pop never frees a slot.
    assign tx_if.tx_ready = (level != (FIFO_AW+1)'(DEPTH));
    assign wr_en          = tx_if.tx_valid & tx_if.tx_ready;
    assign fifo_nempty    = (level != '0);
    assign baud_done      = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    midi_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (tx_if.tx_data),
        .rd_en (rd_en),
        .dout  (fifo_dout),
        .level (level)
    );

    // Frame sequencing: next state, counters, shift register and FIFO pop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (fifo_nempty) begin
                    rd_en   = 1'b1;
                    shift_d = fifo_dout;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (fifo_nempty) begin
                        rd_en   = 1'b1;
                        shift_d = fifo_dout;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level for the cell currently being timed by the FSM.
    always_comb begin
        midi_out_d = 1'b1;
        case (state_q)
            ST_START: midi_out_d = 1'b0;
            ST_DATA:  midi_out_d = shift_q[0];
            default:  midi_out_d = 1'b1;
        endcase
    end

    // FSM and datapath registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            midi_out_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            midi_out_q <= midi_out_d;
        end
    end

    assign midi_out   = midi_out_q;
    assign busy       = (state_q != ST_IDLE) | fifo_nempty;
    assign fifo_level = level;

endmodule
